tx_ds_char: RTL and testbench

- Transmit-side character encoder for the DS link; mirror of rx_DS_char.
- Accepts N-chars (8-bit data) and L-chars (2-bit control codes) from the link layer.
- Computes odd parity and emits the character as a stream of 2-bit pairs to the tx_DS_SE serializer, first-transmitted bit in d[0].
- Fills idle time with NULLs (ESC followed by FCT).

---
 rtl/tx_ds_char_pkg.sv | 22 ++
 rtl/tx_ds_char.sv | 132 +++++++++++++
 tb/tb_tx_ds_char.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/tx_ds_char_pkg.sv
// rtl/tx_ds_char_pkg.sv - DS link character definitions shared by the transmit and receive encoders
package tx_ds_char_pkg;

  localparam logic [1:0] LCODE_FCT = 2'b00;
  localparam logic [1:0] LCODE_EOP = 2'b01;
  localparam logic [1:0] LCODE_EEP = 2'b10;
  localparam logic [1:0] LCODE_ESC = 2'b11;

  localparam int NCHAR_PAIRS = 5;
  localparam int LCHAR_PAIRS = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ds_state_t;

  // Odd parity over previous character's data bits plus this character's flag.
  function automatic logic parity_bit(input logic prevx, input logic flag);
    return ~(prevx ^ flag);
  endfunction

endpackage

// File: rtl/tx_ds_char.sv
// rtl/tx_ds_char.sv - DS link transmit character encoder emitting registered bit pairs
module tx_ds_char
  import tx_ds_char_pkg::*;
#(
  parameter bit IDLE_NULL = 1'b1
) (
  input  logic       txClk,
  input  logic       txReset,
  input  logic       charValid,
  input  logic       charIsL,
  input  logic [7:0] charData,
  output logic       charReady,
  output logic [1:0] d,
  output logic       dValid,
  input  logic       dTake
);

  ds_state_t  state, state_nxt;
  logic [2:0] pair_cnt, pair_nxt;
  logic       cur_isl, cur_isl_nxt;
  logic [7:0] cur_data, cur_data_nxt;
  logic       prevx, prevx_nxt;
  logic       null_owed, null_nxt;
  logic       hold_valid, hold_valid_nxt;
  logic       hold_isl;
  logic [7:0] hold_data;
  logic [1:0] d_nxt;
  logic       dvalid_nxt;

  logic       consume, last_pair, boundary, cur_x, load;
  logic       start, sel_isl, take_hold;
  logic [7:0] sel_data;

  assign charReady = ~hold_valid;

  always_comb begin
    consume   = dTake && dValid;
    last_pair = cur_isl ? (pair_cnt == 3'(LCHAR_PAIRS - 1))
                        : (pair_cnt == 3'(NCHAR_PAIRS - 1));
    boundary  = (state == ST_IDLE) || (consume && last_pair);
    cur_x     = cur_isl ? ^cur_data[1:0] : ^cur_data;
    // The finishing character's parity must feed the flag pair loaded on the same edge.
    prevx_nxt = (state == ST_SEND && consume && last_pair) ? cur_x : prevx;
    load      = charValid && !hold_valid;

    state_nxt      = state;
    pair_nxt       = pair_cnt;
    d_nxt          = d;
    dvalid_nxt     = dValid;
    cur_isl_nxt    = cur_isl;
    cur_data_nxt   = cur_data;
    null_nxt       = null_owed;
    hold_valid_nxt = hold_valid;
    start          = 1'b0;
    sel_isl        = 1'b0;
    sel_data       = 8'h00;
    take_hold      = 1'b0;

    if (boundary) begin
      if (null_owed) begin
        start    = 1'b1;
        sel_isl  = 1'b1;
        sel_data = {6'b0, LCODE_FCT};
        null_nxt = 1'b0;
      end else if (hold_valid) begin
        start     = 1'b1;
        sel_isl   = hold_isl;
        sel_data  = hold_data;
        take_hold = 1'b1;
      end else if (IDLE_NULL) begin
        start    = 1'b1;
        sel_isl  = 1'b1;
        sel_data = {6'b0, LCODE_ESC};
        null_nxt = 1'b1;
      end else begin
        state_nxt  = ST_IDLE;
        pair_nxt   = 3'd0;
        d_nxt      = 2'b00;
        dvalid_nxt = 1'b0;
      end
    end else if (consume) begin
      pair_nxt = pair_cnt + 3'd1;
      d_nxt    = cur_data[{pair_cnt[1:0], 1'b0} +: 2];
    end

    if (start) begin
      state_nxt    = ST_SEND;
      pair_nxt     = 3'd0;
      cur_isl_nxt  = sel_isl;
      cur_data_nxt = sel_data;
      d_nxt        = {sel_isl, parity_bit(prevx_nxt, sel_isl)};
      dvalid_nxt   = 1'b1;
    end

    if (take_hold) begin
      hold_valid_nxt = 1'b0;
    end else if (load) begin
      hold_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge txClk or posedge txReset) begin
    if (txReset) begin
      state      <= ST_IDLE;
      pair_cnt   <= 3'd0;
      cur_isl    <= 1'b0;
      cur_data   <= 8'h00;
      prevx      <= 1'b0;
      null_owed  <= 1'b0;
      hold_valid <= 1'b0;
      hold_isl   <= 1'b0;
      hold_data  <= 8'h00;
      d          <= 2'b00;
      dValid     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pair_cnt   <= pair_nxt;
      cur_isl    <= cur_isl_nxt;
      cur_data   <= cur_data_nxt;
      prevx      <= prevx_nxt;
      null_owed  <= null_nxt;
      hold_valid <= hold_valid_nxt;
      d          <= d_nxt;
      dValid     <= dvalid_nxt;
      if (load) begin
        hold_isl  <= charIsL;
        hold_data <= charData;
      end
    end
  end

endmodule

// File: tb/tb_tx_ds_char.sv
// tb/tb_tx_ds_char.sv - randomized check of tx_ds_char against a character-level reference model
module tb_tx_ds_char;

  logic       txClk = 1'b0;
  logic       txReset;
  logic       charValid;
  logic       charIsL;
  logic [7:0] charData;
  logic       dTake;
  logic       cr0, dv0, cr1, dv1;
  logic [1:0] d0, d1;

  always #5 txClk = ~txClk;

  tx_ds_char #(.IDLE_NULL(1'b1)) u0 (
    .txClk(txClk), .txReset(txReset), .charValid(charValid), .charIsL(charIsL),
    .charData(charData), .charReady(cr0), .d(d0), .dValid(dv0), .dTake(dTake)
  );

  tx_ds_char #(.IDLE_NULL(1'b0)) u1 (
    .txClk(txClk), .txReset(txReset), .charValid(charValid), .charIsL(charIsL),
    .charData(charData), .charReady(cr1), .d(d1), .dValid(dv1), .dTake(dTake)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: index 0 sends NULLs when idle, index 1 goes quiet.
  logic [1:0] m_pairs [2][5];
  int         m_len   [2];
  int         m_idx   [2];
  bit         m_valid [2];
  bit         m_idle  [2];
  bit         m_full  [2];
  bit         m_hisl  [2];
  logic [7:0] m_hdata [2];
  bit         m_prevx [2];
  bit         m_owed  [2];
  bit         m_curx  [2];
  logic [1:0] log0[$];
  logic [1:0] log1[$];

  task automatic start_char(input int k, input bit isl, input logic [7:0] data);
    m_pairs[k][0] = {isl, ~(m_prevx[k] ^ isl)};
    if (isl) begin
      m_len[k]      = 2;
      m_pairs[k][1] = data[1:0];
      m_curx[k]     = ($countones(data[1:0]) % 2) == 1;
    end else begin
      m_len[k] = 5;
      for (int i = 0; i < 4; i++) m_pairs[k][i+1] = data[2*i +: 2];
      m_curx[k] = ($countones(data) % 2) == 1;
    end
    m_idx[k]   = 0;
    m_valid[k] = 1'b1;
    m_idle[k]  = 1'b0;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_idle[k] = 1'b1; m_valid[k] = 1'b0; m_full[k] = 1'b0;
      m_prevx[k] = 1'b0; m_owed[k] = 1'b0; m_idx[k] = 0; m_len[k] = 5;
    end
  endtask

  task automatic model_step(input int k, input bit cv, input bit il, input logic [7:0] cd, input bit tk);
    bit load, bnd;
    load = cv && !m_full[k];
    bnd  = m_idle[k] || (tk && m_valid[k] && m_idx[k] == m_len[k] - 1);
    if (!bnd && tk && m_valid[k]) m_idx[k]++;
    if (bnd) begin
      if (!m_idle[k]) m_prevx[k] = m_curx[k];
      if (m_owed[k]) begin
        start_char(k, 1'b1, 8'h00);
        m_owed[k] = 1'b0;
      end else if (m_full[k]) begin
        start_char(k, m_hisl[k], m_hdata[k]);
        m_full[k] = 1'b0;
      end else if (k == 0) begin
        start_char(k, 1'b1, 8'h03);
        m_owed[k] = 1'b1;
      end else begin
        m_idle[k]  = 1'b1;
        m_valid[k] = 1'b0;
      end
    end
    if (load) begin
      m_full[k] = 1'b1; m_hisl[k] = il; m_hdata[k] = cd;
    end
  endtask

  task automatic compare_outputs();
    check("dvalid0", dv0, m_valid[0]);
    check("d0", d0, m_valid[0] ? m_pairs[0][m_idx[0]] : 2'b00);
    check("ready0", cr0, !m_full[0]);
    check("dvalid1", dv1, m_valid[1]);
    check("d1", d1, m_valid[1] ? m_pairs[1][m_idx[1]] : 2'b00);
    check("ready1", cr1, !m_full[1]);
  endtask

  // Entered and left at a negative edge.
  task automatic tick(input bit cv, input bit il, input logic [7:0] cd, input bit tk);
    compare_outputs();
    if (tk && dv0) log0.push_back(d0);
    if (tk && dv1) log1.push_back(d1);
    charValid = cv; charIsL = il; charData = cd; dTake = tk;
    @(posedge txClk);
    if (txReset) model_reset();
    else begin
      model_step(0, cv, il, cd, tk);
      model_step(1, cv, il, cd, tk);
    end
    @(negedge txClk);
  endtask

  task automatic offer(input bit il, input logic [7:0] cd);
    int w;
    w = 0;
    while (!cr1 && w < 20) begin
      tick(1'b0, 1'b0, 8'h00, 1'b1);
      w++;
    end
    check("offer_ready", cr1, 1'b1);
    tick(1'b1, il, cd, 1'b1);
  endtask

  task automatic pulse_reset();
    txReset = 1'b1;
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    txReset = 1'b0;
  endtask

  logic [7:0] chars [4];
  logic [1:0] exp_l3 [7];

  initial begin
    bit cv, il, tk, acc, saw_low, did_rst;
    logic [7:0] cd;
    int j, w;

    txReset = 1'b1; charValid = 1'b0; charIsL = 1'b0; charData = 8'h00; dTake = 1'b0;
    model_reset();
    @(negedge txClk);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    tick(1'b0, 1'b0, 8'h00, 1'b1);
    txReset = 1'b0;

    // NULL stream with dTake every other cycle
    log0.delete(); log1.delete();
    for (int i = 0; i < 24; i++) tick(1'b0, 1'b0, 8'h00, (i % 2) == 1);
    check("null_p0", log0[0], 2'b10);
    check("null_p1", log0[1], 2'b11);
    check("null_p2", log0[2], 2'b10);
    check("null_p3", log0[3], 2'b00);
    check("null_p4", log0[4], 2'b10);
    check("null_p7", log0[7], 2'b00);
    check("quiet1_pairs", 8'(log1.size()), 8'd0);

    // N-char 0x41 then L-char EEP on the quiet instance
    log1.delete();
    offer(1'b0, 8'h41);
    offer(1'b1, 8'h02);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
    exp_l3 = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10, 2'b10};
    check("l3_count", 8'(log1.size()), 8'd7);
    for (int i = 0; i < 7; i++) check($sformatf("l3_p%0d", i), log1[i], exp_l3[i]);

    // Back-to-back N-chars with charValid held
    pulse_reset();
    log1.delete();
    chars = '{8'h41, 8'h62, 8'h63, 8'h64};
    j = 0; w = 0; saw_low = 1'b0;
    while (j < 4 && w < 100) begin
      acc = cr1;
      if (!cr1) saw_low = 1'b1;
      tick(1'b1, 1'b0, chars[j], 1'b1);
      if (acc) j++;
      w++;
    end
    check("b2b_accepted", 8'(j), 8'd4);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0, 8'h00, 1'b1);
    check("b2b_ready_drop", saw_low, 1'b1);
    check("b2b_count", 8'(log1.size()), 8'd20);
    check("b2b_flag0", log1[0], 2'b01);
    check("b2b_flag1", log1[5], 2'b01);
    check("b2b_flag2", log1[10], 2'b00);
    check("b2b_flag3", log1[15], 2'b01);

    // Random traffic, with one asynchronous reset in the middle of an N-char
    did_rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!did_rst && i > 500 && m_valid[0] && m_len[0] == 5 && m_idx[0] == 2) begin
        txReset = 1'b1;
        #1;
        check("async_dvalid0", dv0, 1'b0);
        check("async_d0", d0, 2'b00);
        check("async_dvalid1", dv1, 1'b0);
        check("async_ready0", cr0, 1'b1);
        model_reset();
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        txReset = 1'b0;
        log0.delete();
        for (int r = 0; r < 4; r++) tick(1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_null_p0", log0[0], 2'b10);
        check("rst_null_p1", log0[1], 2'b11);
        did_rst = 1'b1;
      end
      cv = (i < 2000) ? ($urandom % 3 == 0) : ($urandom % 16 == 0);
      il = $urandom % 2;
      cd = 8'($urandom);
      tk = ($urandom % 4) != 0;
      tick(cv, il, cd, tk);
    end
    check("mid_reset_hit", did_rst, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
